fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register for the pipelined CPU.
- Owns the PC and issues one-at-a-time requests to instruction memory over a variable-latency req/valid handshake.
- Buffers the returned word under stall and discards in-flight words on branch redirect.
- Presents the decoded 4-bit opCode and IF/ID payload directly to the control unit in decode.

Parameters:
- ADDR_W, 32, PC / instruction-memory address width.
- INSTR_W, 32, instruction width; opCode = instr[INSTR_W-1 -: 4].
- RESET_PC, 0, PC value after reset.
- NOP_OP, 4'b1111, opCode driven when IF/ID holds a bubble.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  hazard unit: hold the IF/ID register.
- redirect  in  1  branch resolved taken: flush and refetch.
- redirect_pc  in  ADDR_W  branch target, sampled when redirect=1.
- imem_req  out  1  one-cycle request pulse.
- imem_addr  out  ADDR_W  request address; stable from the req cycle until its response.
- imem_valid  in  1  response strobe; at most one per request, ≥1 cycle after req.
- imem_rdata  in  INSTR_W  instruction word, valid with imem_valid.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_instr  out  INSTR_W  registered instruction.
- if_id_pc  out  ADDR_W  address of if_id_instr.
- if_id_pc_next  out  ADDR_W  if_id_pc + 4.
- opCode  out  4  to control unit: if_id_instr[INSTR_W-1 -: 4] if if_id_valid, else NOP_OP (combinational from the register).

Behaviour:
- Reset (async, immediate):
  - pc_q = RESET_PC; state = FETCH; kill = 0; buffer empty.
  - imem_req = 0; imem_addr = RESET_PC.
  - if_id_valid = 0; if_id_instr = 0; if_id_pc = 0; if_id_pc_next = 0; opCode = NOP_OP.
- FSM states: FETCH, WAIT, HOLD.
- FETCH:
  - Without redirect: imem_req = 1 and imem_addr = pc_q for exactly one cycle, then -> WAIT.
  - With redirect in the same cycle: no request. pc_q <= redirect_pc; stay FETCH.
- WAIT, on imem_valid:
  - kill = 1 or redirect = 1: discard the word; kill <= 0; -> FETCH.
  - Else if stall = 0: IF/ID <= {1, rdata, pc_q, pc_q+4}; pc_q <= pc_q+4; -> FETCH.
  - Else: buffer <= {rdata, pc_q}; pc_q <= pc_q+4; -> HOLD.
- WAIT, no imem_valid: a redirect sets kill <= 1 and pc_q <= redirect_pc. imem_addr stays at the old address until the response arrives.
- HOLD (no requests issued):
  - Redirect: drop the buffer; pc_q <= redirect_pc; -> FETCH.
  - Else if stall = 0: IF/ID <= buffer contents with valid = 1; -> FETCH.
- IF/ID register update rules:
  - redirect = 1: if_id_valid <= 0 next cycle. Redirect wins over stall.
  - stall = 1 without redirect: all IF/ID fields hold.
  - stall = 0 and no word loaded this cycle: if_id_valid <= 0 (bubble). instr/pc fields hold their values, so opCode = NOP_OP.
- Throughput: with 1-cycle memory latency, one instruction every 2 cycles. Back-to-back requests are not supported; at most one request is outstanding.
- Arithmetic: pc_q + 4 is modulo 2^ADDR_W; wrap from all-ones-minus-3 to 0 is silent.
- Redirect in the same cycle as imem_valid in WAIT: the word is discarded, and the next request goes to redirect_pc.
- Stall asserted for N cycles in HOLD: exactly one buffered word, no new imem_req, and IF/ID unchanged.
- Reset mid-WAIT: the outstanding response is ignored. After reset the state is FETCH with kill = 0, so the bench must not return a stale imem_valid after reset.

Test Plan:
- Reset release with RESET_PC = 0 and 1-cycle memory returning 0x1000_0000, 0x2000_0000:
  - imem_req at addrs 0, 4.
  - IF/ID pcs 0 and 4, with pc_next 4 and 8.
  - opCode 4'b0001 then 4'b0010, NOP_OP between them.
- Memory latency 3 cycles: imem_addr is held for 3 cycles; exactly one req per instruction; if_id_valid pulses once per 4 cycles.
- stall held 5 cycles while the word from addr 8 returns:
  - IF/ID holds the addr-4 instruction throughout.
  - No imem_req during HOLD.
  - After stall drops: IF/ID pc = 8, then next req at 12.
- Redirect to 0x40 while WAIT for addr 12 (response arrives 2 cycles later):
  - Returned word discarded and if_id_valid = 0.
  - Next req at 0x40; the addr-12 word never reaches IF/ID.
- Redirect to 0x80 and stall both high in the same cycle: if_id_valid = 0 next cycle and opCode = NOP_OP; next fetch at 0x80.
- Async rst asserted mid-WAIT: all outputs reach reset values without a clock edge; the first req after release is at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// One outstanding imem request at a time; a stalled response is parked in a one-word buffer.
module fetch_stage #(
   parameter int              ADDR_W   = 32,
   parameter int              INSTR_W  = 32,
   parameter logic [ADDR_W-1:0] RESET_PC = '0,
   parameter logic [3:0]      NOP_OP   = 4'b1111
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stall,
   input  logic               redirect,
   input  logic [ADDR_W-1:0]  redirect_pc,
   output logic               imem_req,
   output logic [ADDR_W-1:0]  imem_addr,
   input  logic               imem_valid,
   input  logic [INSTR_W-1:0] imem_rdata,
   output logic               if_id_valid,
   output logic [INSTR_W-1:0] if_id_instr,
   output logic [ADDR_W-1:0]  if_id_pc,
   output logic [ADDR_W-1:0]  if_id_pc_next,
   output logic [3:0]         opCode
);

   typedef enum logic [1:0] {S_FETCH, S_WAIT, S_HOLD} state_t;

   state_t               state_q, state_d;
   logic [ADDR_W-1:0]    pc_q, pc_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic                 kill_q, kill_d;
   logic [INSTR_W-1:0]   buf_instr_q, buf_instr_d;
   logic [ADDR_W-1:0]    buf_pc_q, buf_pc_d;
   logic                 v_q, v_d;
   logic [INSTR_W-1:0]   instr_q, instr_d;
   logic [ADDR_W-1:0]    ipc_q, ipc_d;
   logic [ADDR_W-1:0]    ipcn_q, ipcn_d;
   logic                 req;
   logic                 load;
   logic [INSTR_W-1:0]   ld_instr;
   logic [ADDR_W-1:0]    ld_pc;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_FETCH;
         pc_q        <= RESET_PC;
         addr_q      <= RESET_PC;
         kill_q      <= 1'b0;
         buf_instr_q <= '0;
         buf_pc_q    <= '0;
         v_q         <= 1'b0;
         instr_q     <= '0;
         ipc_q       <= '0;
         ipcn_q      <= '0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         addr_q      <= addr_d;
         kill_q      <= kill_d;
         buf_instr_q <= buf_instr_d;
         buf_pc_q    <= buf_pc_d;
         v_q         <= v_d;
         instr_q     <= instr_d;
         ipc_q       <= ipc_d;
         ipcn_q      <= ipcn_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      addr_d      = addr_q;
      kill_d      = kill_q;
      buf_instr_d = buf_instr_q;
      buf_pc_d    = buf_pc_q;
      req         = 1'b0;
      load        = 1'b0;
      ld_instr    = imem_rdata;
      ld_pc       = pc_q;

      case (state_q)
         S_FETCH: begin
            if (redirect) begin
               pc_d = redirect_pc;
            end else begin
               req     = 1'b1;
               addr_d  = pc_q;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (imem_valid) begin
               // A redirect seen earlier (kill) or now makes this word stale.
               if (kill_q || redirect) begin
                  kill_d  = 1'b0;
                  state_d = S_FETCH;
                  if (redirect) pc_d = redirect_pc;
               end else if (!stall) begin
                  load    = 1'b1;
                  pc_d    = pc_q + ADDR_W'(4);
                  state_d = S_FETCH;
               end else begin
                  buf_instr_d = imem_rdata;
                  buf_pc_d    = pc_q;
                  pc_d        = pc_q + ADDR_W'(4);
                  state_d     = S_HOLD;
               end
            end else if (redirect) begin
               kill_d = 1'b1;
               pc_d   = redirect_pc;
            end
         end
         S_HOLD: begin
            if (redirect) begin
               pc_d    = redirect_pc;
               state_d = S_FETCH;
            end else if (!stall) begin
               load     = 1'b1;
               ld_instr = buf_instr_q;
               ld_pc    = buf_pc_q;
               state_d  = S_FETCH;
            end
         end
         default: state_d = S_FETCH;
      endcase

      v_d     = v_q;
      instr_d = instr_q;
      ipc_d   = ipc_q;
      ipcn_d  = ipcn_q;
      // Redirect flushes even under stall; an unstalled cycle without a word inserts a bubble.
      if (redirect) begin
         v_d = 1'b0;
      end else if (!stall) begin
         v_d = load;
         if (load) begin
            instr_d = ld_instr;
            ipc_d   = ld_pc;
            ipcn_d  = ld_pc + ADDR_W'(4);
         end
      end
   end

   assign imem_req      = req && !rst;
   assign imem_addr     = (state_q == S_FETCH) ? pc_q : addr_q;
   assign if_id_valid   = v_q;
   assign if_id_instr   = instr_q;
   assign if_id_pc      = ipc_q;
   assign if_id_pc_next = ipcn_q;
   assign opCode        = v_q ? instr_q[INSTR_W-1 -: 4] : NOP_OP;

endmodule
